cmac_seq_mult_acc: RTL and testbench

//  Parametrised successor to the fixed 4x4 recursive multiplier in the CMAC datapath: unsigned DW x DW multiply-accumulate.

---
 rtl/cmac_mult_pkg.sv | 22 ++
 rtl/cmac_pp2x2.sv | 26 ++
 rtl/cmac_seq_mult_acc.sv | 113 +++++++++++
 tb/tb_cmac_seq_mult_acc.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmac_mult_pkg.sv
// Shared types and constants for the sequential CMAC multiply-accumulate.
// CMAC_APPROX_2X2_EN selects the 3-bit approximate 2x2 cell width.
package cmac_mult_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBusy,
      StDone
   } state_e;

`ifdef CMAC_APPROX_2X2_EN
   localparam int unsigned CELL_W = 3;
`else
   localparam int unsigned CELL_W = 4;
`endif

   // Number of 2-bit digits of b, which is also the BUSY cycle count.
   function automatic int unsigned ndig(input int unsigned dw);
      return dw / 2;
   endfunction

endpackage

// File: rtl/cmac_pp2x2.sv
// Combinational 2x2 unsigned partial-product cell.
// With CMAC_APPROX_2X2_EN defined, 3x3 returns 7; all other products stay exact.
module cmac_pp2x2
   import cmac_mult_pkg::*;
(
   input  logic [1:0]        a,
   input  logic [1:0]        b,
   output logic [CELL_W-1:0] p
);

   logic [3:0] prod;

   assign prod = {2'b00, a} * {2'b00, b};

`ifdef CMAC_APPROX_2X2_EN
   always_comb begin
      p = CELL_W'(prod);
      if (a == 2'd3 && b == 2'd3) begin
         p = 3'b111;
      end
   end
`else
   assign p = prod;
`endif

endmodule

// File: rtl/cmac_seq_mult_acc.sv
// Sequential unsigned DW x DW multiply-accumulate, one 2-bit digit of b per cycle.
// Define CMAC_APPROX_2X2_EN to build with the approximate 2x2 cells.
module cmac_seq_mult_acc
   import cmac_mult_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned ACC_W = 2 * DW + 4
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_a,
   input  logic [DW-1:0]    in_b,
   input  logic             in_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data
);

   localparam int unsigned NDIG  = ndig(DW);
   localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int unsigned ROW_W = DW + 2;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [DW-1:0]    a_q;
   logic [DW-1:0]    b_q;
   logic [ACC_W-1:0] acc_q;
   logic             in_ready_q;
   logic             out_valid_q;

   logic [1:0]        b_dig;
   logic [CELL_W-1:0] cell_p [NDIG];
   logic [ROW_W-1:0]  row;
   logic [ACC_W-1:0]  row_sh;

   assign b_dig = 2'(b_q >> {cnt_q, 1'b0});

   for (genvar k = 0; k < NDIG; k++) begin : g_cell
      cmac_pp2x2 u_cell (
         .a (a_q[2*k+1:2*k]),
         .b (b_dig),
         .p (cell_p[k])
      );
   end

   always_comb begin
      row = '0;
      for (int k = 0; k < NDIG; k++) begin
         row = row + (ROW_W'(cell_p[k]) << (2 * k));
      end
   end

   assign row_sh = ACC_W'(row) << {cnt_q, 1'b0};

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= in_a;
                  b_q        <= in_b;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  if (!in_acc) begin
                     acc_q <= '0;
                  end
                  // A zero operand adds nothing, so skip the digit loop entirely.
                  if (in_a == '0 || in_b == '0) begin
                     state_q     <= StDone;
                     out_valid_q <= 1'b1;
                  end else begin
                     state_q <= StBusy;
                  end
               end
            end
            StBusy: begin
               acc_q <= acc_q + row_sh;
               if (cnt_q == CNT_W'(NDIG - 1)) begin
                  state_q     <= StDone;
                  out_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = acc_q;

endmodule

// File: tb/tb_cmac_seq_mult_acc.sv
// Directed bench for cmac_seq_mult_acc: DW=8 with ACC_W=20 and a parallel ACC_W=16 instance.
// Expected values follow CMAC_APPROX_2X2_EN when it is defined.
module tb_cmac_seq_mult_acc;

   logic        clk  = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic        in_acc = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [19:0] out_data;
   logic        in_ready16, out_valid16;
   logic [15:0] out_data16;

   int checks = 0;
   int errors = 0;

`ifdef CMAC_APPROX_2X2_EN
   localparam logic [19:0] EXP_FF    = 20'd50575;
   localparam logic [19:0] EXP_FF2   = 20'd101150;
   localparam logic [15:0] EXP_FF2_W = 16'd35614;
`else
   localparam logic [19:0] EXP_FF    = 20'd65025;
   localparam logic [19:0] EXP_FF2   = 20'd130050;
   localparam logic [15:0] EXP_FF2_W = 16'd64514;
`endif

   always #5 clk = ~clk;

   cmac_seq_mult_acc #(.DW(8), .ACC_W(20)) dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_a            (in_a),
      .in_b            (in_b),
      .in_acc          (in_acc),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data)
   );

   cmac_seq_mult_acc #(.DW(8), .ACC_W(16)) dut16 (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .in_valid        (in_valid),
      .in_ready        (in_ready16),
      .in_a            (in_a),
      .in_b            (in_b),
      .in_acc          (in_acc),
      .out_valid       (out_valid16),
      .out_ready       (out_ready),
      .out_data        (out_data16)
   );

   // Issue one beat, then wait (bounded) for out_valid; lat counts cycles from the accept edge.
   task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic acc,
                           output logic [19:0] data, output logic [15:0] data16,
                           output int lat);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_ready got %b want 1", in_ready);
      end
      in_a = a; in_b = b; in_acc = acc; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL out_valid_timeout got %b want 1 after %0d cycles", out_valid, lat);
      end
      data   = out_data;
      data16 = out_data16;
   endtask

   task automatic end_op;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL out_valid_drop got %b want 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL in_ready_return got %b want 1", in_ready);
      end
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      checks++;
      if (out_data !== 20'd0) begin
         errors++; $display("FAIL reset_out_data got %0d want 0", out_data);
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_exact;
      logic [19:0] d;
      logic [15:0] d16;
      int          lat;
      start_op(8'd255, 8'd255, 1'b0, d, d16, lat);
      checks++;
      if (d !== EXP_FF) begin
         errors++; $display("FAIL mult_ff got %0d want %0d", d, EXP_FF);
      end
      checks++;
      if (lat !== 5) begin
         errors++; $display("FAIL latency_nonzero got %0d want 5", lat);
      end
      end_op();
      start_op(8'd2, 8'd3, 1'b0, d, d16, lat);
      checks++;
      if (d !== 20'd6) begin
         errors++; $display("FAIL mult_2x3 got %0d want 6", d);
      end
      end_op();
   endtask

   task automatic test_accumulate;
      logic [19:0] d;
      logic [15:0] d16;
      int          lat;
      start_op(8'd3, 8'd4, 1'b0, d, d16, lat);
      checks++;
      if (d !== 20'd12) begin
         errors++; $display("FAIL acc_first got %0d want 12", d);
      end
      end_op();
      start_op(8'd10, 8'd10, 1'b1, d, d16, lat);
      checks++;
      if (d !== 20'd112) begin
         errors++; $display("FAIL acc_second got %0d want 112", d);
      end
      end_op();
      start_op(8'd0, 8'd9, 1'b1, d, d16, lat);
      checks++;
      if (d !== 20'd112) begin
         errors++; $display("FAIL acc_zero got %0d want 112", d);
      end
      checks++;
      if (lat !== 1) begin
         errors++; $display("FAIL latency_zero got %0d want 1", lat);
      end
      end_op();
   endtask

   task automatic test_backpressure;
      logic [19:0] d;
      logic [15:0] d16;
      int          lat;
      start_op(8'd7, 8'd9, 1'b0, d, d16, lat);
      checks++;
      if (d !== 20'd63) begin
         errors++; $display("FAIL bp_result got %0d want 63", d);
      end
      // A beat offered while DONE must be ignored.
      in_a = 8'd5; in_b = 8'd5; in_acc = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 20'd63) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got valid=%b ready=%b data=%0d want 1 0 63",
                     i, out_valid, in_ready, out_data);
         end
      end
      in_valid = 1'b0;
      end_op();
      start_op(8'd1, 8'd1, 1'b1, d, d16, lat);
      checks++;
      if (d !== 20'd64) begin
         errors++; $display("FAIL bp_no_extra_beat got %0d want 64", d);
      end
      end_op();
   endtask

   task automatic test_wrap;
      logic [19:0] d;
      logic [15:0] d16;
      int          lat;
      start_op(8'd255, 8'd255, 1'b0, d, d16, lat);
      end_op();
      start_op(8'd255, 8'd255, 1'b1, d, d16, lat);
      checks++;
      if (d16 !== EXP_FF2_W) begin
         errors++; $display("FAIL wrap_16 got %0d want %0d", d16, EXP_FF2_W);
      end
      checks++;
      if (d !== EXP_FF2) begin
         errors++; $display("FAIL nowrap_20 got %0d want %0d", d, EXP_FF2);
      end
      end_op();
   endtask

   task automatic test_reset_mid_busy;
      logic [19:0] d;
      logic [15:0] d16;
      int          lat;
      @(negedge clk);
      in_a = 8'd200; in_b = 8'd200; in_acc = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL busy_in_ready got %b want 0", in_ready);
      end
      rstn = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 20'd0) begin
         errors++;
         $display("FAIL mid_reset got valid=%b ready=%b data=%0d want 0 1 0",
                  out_valid, in_ready, out_data);
      end
      @(negedge clk);
      rstn = 1'b1;
      start_op(8'd3, 8'd4, 1'b1, d, d16, lat);
      checks++;
      if (d !== 20'd12) begin
         errors++; $display("FAIL after_reset got %0d want 12", d);
      end
      end_op();
   endtask

   initial begin
      test_reset();
      test_exact();
      test_accumulate();
      test_backpressure();
      test_wrap();
      test_reset_mid_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
